// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller and the core top that consumes its controls.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the core and stall/flush controls back to its pipeline registers.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_is_load;
    logic                  ex_mdu_valid;
    logic                  ex_redirect;
    logic                  imem_wait;
    logic                  dmem_wait;

    logic stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic mdu_done;
    logic [CNT_W-1:0] perf_stall_cyc;
    logic [CNT_W-1:0] perf_redirects;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_mdu_valid, ex_redirect, imem_wait, dmem_wait,
        input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               mdu_done, perf_stall_cyc, perf_redirects
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
               ex_mdu_valid, ex_redirect, imem_wait, dmem_wait,
        output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb,
               mdu_done, perf_stall_cyc, perf_redirects
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_latency_timer.sv
// Tracks how long a fixed-latency MUL/DIV op has occupied EX and flags its final cycle.
module mdu_latency_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic dmem_wait,
    output logic mdu_busy,
    output logic mdu_done
);
    localparam int CW = $clog2(MDU_CYCLES);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_INIT = cnt_t'(MDU_CYCLES - 2);

    mdu_state_e state_reg;
    cnt_t       cnt_reg;
    logic       done_reg;

    // done_reg is kept equal to (state==BUSY && cnt==0) by computing it from the next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= BUSY;
                        cnt_reg   <= CNT_INIT;
                        done_reg  <= (CNT_INIT == '0);
                    end
                end
                BUSY: begin
                    if (cnt_reg != '0) begin
                        cnt_reg  <= cnt_reg - cnt_t'(1);
                        done_reg <= (cnt_reg == cnt_t'(1));
                    end else if (!dmem_wait) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign mdu_busy = (state_reg == BUSY);
    assign mdu_done = done_reg;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Priority resolver producing per-register stall/flush for the 5-stage core, plus perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    logic mdu_busy, mdu_done;
    logic mdu_stall, load_use, upper_hold, redirect_acc;
    logic pc_stall;
    stage_ctrl_t stage_c [4];   // ifid, idex, exmem, memwb

    logic [CNT_W-1:0] stall_cyc_reg;
    logic [CNT_W-1:0] redirects_reg;

    mdu_latency_timer #(.MDU_CYCLES(MDU_CYCLES)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (bus.ex_mdu_valid),
        .dmem_wait (bus.dmem_wait),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done)
    );

    // An accepted redirect owns pc/ifid/idex, so load-use and imem_wait cannot touch them.
    always_comb begin
        mdu_stall    = bus.ex_mdu_valid && !mdu_done;
        load_use     = bus.ex_is_load && (bus.ex_rd != '0) &&
                       ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                        (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
        upper_hold   = bus.dmem_wait || mdu_stall;
        redirect_acc = bus.ex_redirect && !upper_hold;

        pc_stall         = upper_hold || (!redirect_acc && (load_use || bus.imem_wait));
        stage_c[0].stall = upper_hold || (!redirect_acc && load_use);
        stage_c[0].flush = !upper_hold && (redirect_acc || (!load_use && bus.imem_wait));
        stage_c[1].stall = upper_hold;
        stage_c[1].flush = !upper_hold && (redirect_acc || load_use);
        stage_c[2].stall = bus.dmem_wait;
        stage_c[2].flush = !bus.dmem_wait && mdu_stall;
        stage_c[3].stall = 1'b0;
        stage_c[3].flush = bus.dmem_wait;
    end

    assign bus.stall_pc    = pc_stall;
    assign bus.stall_ifid  = stage_c[0].stall;
    assign bus.flush_ifid  = stage_c[0].flush;
    assign bus.stall_idex  = stage_c[1].stall;
    assign bus.flush_idex  = stage_c[1].flush;
    assign bus.stall_exmem = stage_c[2].stall;
    assign bus.flush_exmem = stage_c[2].flush;
    assign bus.stall_memwb = stage_c[3].stall;
    assign bus.flush_memwb = stage_c[3].flush;
    assign bus.mdu_done    = mdu_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_reg <= '0;
            redirects_reg <= '0;
        end else begin
            if (pc_stall)     stall_cyc_reg <= stall_cyc_reg + 1'b1;
            if (redirect_acc) redirects_reg <= redirects_reg + 1'b1;
        end
    end

    assign bus.perf_stall_cyc = stall_cyc_reg;
    assign bus.perf_redirects = redirects_reg;

    // A register seeing both would take the flush and silently drop its instruction.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_no_collision
            a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
                !(stage_c[gi].stall && stage_c[gi].flush));
        end
    endgenerate

    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) mdu_done |-> mdu_busy);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: driver predicts each cycle's controls from a rule-table model, monitor compares.
module tb_pipe_hazard_ctrl;
    localparam int MDU_CYCLES = 4;
    localparam int CNT_W      = 32;
    localparam int NONE = 0, STALL = 1, FLUSH = 2;

    typedef struct packed {
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] rd;
        logic       is_load, mdu_valid, redirect, imem_wait, dmem_wait;
    } stim_t;

    typedef struct packed {
        logic [4:0]       stall;   // {memwb, exmem, idex, ifid, pc}
        logic [4:0]       flush;
        logic             done;
        logic [CNT_W-1:0] pstall;
        logic [CNT_W-1:0] predir;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    // Reference model: MDU op age in EX plus plain event counts.
    bit               m_in_op;
    int               m_age;
    logic [CNT_W-1:0] m_pstall, m_predir;
    int               m_act[5];
    bit               m_claim[5];

    task automatic claim(input int r, input int a);
        if (!m_claim[r]) begin
            m_claim[r] = 1'b1;
            m_act[r]   = a;
        end
    endtask

    task automatic model_reset();
        m_in_op  = 1'b0;
        m_age    = 0;
        m_pstall = '0;
        m_predir = '0;
    endtask

    task automatic model_step(input stim_t s, output exp_t e);
        bit done, mstall, lu, redir;
        for (int r = 0; r < 5; r++) begin
            m_act[r] = NONE;
            m_claim[r] = 1'b0;
        end
        done   = m_in_op && (m_age >= MDU_CYCLES - 1);
        mstall = s.mdu_valid && !done;
        lu     = s.is_load && (s.rd != 0) &&
                 ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        redir  = s.redirect && !s.dmem_wait && !mstall;
        if (s.dmem_wait) begin
            for (int r = 0; r < 4; r++) claim(r, STALL);
            claim(4, FLUSH);
        end
        if (mstall) begin
            for (int r = 0; r < 3; r++) claim(r, STALL);
            claim(3, FLUSH);
        end
        if (redir) begin
            claim(0, NONE);
            claim(1, FLUSH);
            claim(2, FLUSH);
        end
        if (lu) begin
            claim(0, STALL);
            claim(1, STALL);
            claim(2, FLUSH);
        end
        if (s.imem_wait) begin
            claim(0, STALL);
            claim(1, FLUSH);
        end
        for (int r = 0; r < 5; r++) begin
            e.stall[r] = (m_act[r] == STALL);
            e.flush[r] = (m_act[r] == FLUSH);
        end
        e.done   = done;
        e.pstall = m_pstall;
        e.predir = m_predir;
        // advance to the next cycle
        if (e.stall[0]) m_pstall = m_pstall + 1'b1;
        if (redir)      m_predir = m_predir + 1'b1;
        if (m_in_op) begin
            if (done && !s.dmem_wait) m_in_op = 1'b0;
            else m_age++;
        end else if (s.mdu_valid) begin
            m_in_op = 1'b1;
            m_age   = 1;
        end
    endtask

    task automatic apply(input stim_t s);
        hif.id_rs1       = s.rs1;
        hif.id_rs2       = s.rs2;
        hif.id_use_rs1   = s.use1;
        hif.id_use_rs2   = s.use2;
        hif.ex_rd        = s.rd;
        hif.ex_is_load   = s.is_load;
        hif.ex_mdu_valid = s.mdu_valid;
        hif.ex_redirect  = s.redirect;
        hif.imem_wait    = s.imem_wait;
        hif.dmem_wait    = s.dmem_wait;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1;
        apply(s);
        model_step(s, e);
        sb_q.push_back(e);
    endtask

    task automatic drive_reset();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        apply('0);
        model_reset();
        e = '0;
        sb_q.push_back(e);
    endtask

    // Monitor: controls are valid every cycle, checked mid-cycle well away from posedge.
    int txn = 0;
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                a.stall  = {hif.stall_memwb, hif.stall_exmem, hif.stall_idex, hif.stall_ifid, hif.stall_pc};
                a.flush  = {hif.flush_memwb, hif.flush_exmem, hif.flush_idex, hif.flush_ifid, 1'b0};
                a.done   = hif.mdu_done;
                a.pstall = hif.perf_stall_cyc;
                a.predir = hif.perf_redirects;
                checks++;
                if (a.stall !== e.stall || a.flush !== e.flush || a.done !== e.done) begin
                    errors++;
                    $display("FAIL txn %0d ctrl: got stall=%b flush=%b done=%b, need stall=%b flush=%b done=%b",
                             txn, a.stall, a.flush, a.done, e.stall, e.flush, e.done);
                end
                checks++;
                if (a.pstall !== e.pstall || a.predir !== e.predir) begin
                    errors++;
                    $display("FAIL txn %0d perf: got stall_cyc=%0d redirects=%0d, need %0d %0d",
                             txn, a.pstall, a.predir, e.pstall, e.predir);
                end
                $display("txn %0d stall=%b flush=%b done=%b perf=%0d/%0d",
                         txn, a.stall, a.flush, a.done, a.pstall, a.predir);
                txn++;
            end
        end
    end

    initial begin
        stim_t s;
        apply('0);
        model_reset();
        drive_reset();

        // load-use hit, then rd=x0 and use_rs1=0 must not stall
        s = '0; s.is_load = 1; s.rd = 5; s.rs1 = 5; s.use1 = 1;
        drive(s);
        drive('0);
        s.rd = 0; s.rs1 = 0;
        drive(s);
        s.rd = 5; s.rs1 = 5; s.use1 = 0;
        drive(s);

        // MDU op held in EX, dmem_wait on its final cycle
        s = '0; s.mdu_valid = 1;
        repeat (3) drive(s);
        s.dmem_wait = 1;
        repeat (2) drive(s);
        s.dmem_wait = 0;
        drive(s);
        drive('0);

        // redirect blocked by dmem_wait, accepted next cycle
        s = '0; s.redirect = 1; s.dmem_wait = 1;
        drive(s);
        s.dmem_wait = 0;
        drive(s);

        // imem_wait together with load-use
        s = '0; s.is_load = 1; s.rd = 7; s.rs2 = 7; s.use2 = 1; s.imem_wait = 1;
        drive(s);
        s = '0; s.imem_wait = 1;
        drive(s);

        // reset in the middle of an MDU op
        s = '0; s.mdu_valid = 1;
        repeat (2) drive(s);
        drive_reset();
        drive('0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive_reset();
            end else begin
                s.rs1       = 5'($urandom_range(0, 3));
                s.rs2       = 5'($urandom_range(0, 3));
                s.rd        = 5'($urandom_range(0, 3));
                s.use1      = 1'($urandom_range(0, 1));
                s.use2      = 1'($urandom_range(0, 1));
                s.is_load   = ($urandom_range(0, 2) == 0);
                s.mdu_valid = m_in_op ? 1'b1 : ($urandom_range(0, 4) == 0);
                s.redirect  = ($urandom_range(0, 3) == 0);
                s.imem_wait = ($urandom_range(0, 3) == 0);
                s.dmem_wait = ($urandom_range(0, 4) == 0);
                drive(s);
            end
        end

        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, need 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
